// File: rtl/cla_mp_add_ctrl_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer.
// Holds the FSM state encoding and the default adder geometry.
package cla_mp_add_ctrl_pkg;

  localparam int W_DEF     = 32;
  localparam int WORDS_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/cla_mp_add_ctrl_word_reg.sv
// W-bit carry-lookahead adder with registered sum and carry-out (latency 1).
// Lookahead is done in 4-bit groups, so W must be a multiple of 4.
module cla_word_reg
  import cla_mp_add_ctrl_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic         co,
  output logic [W-1:0] s
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = ci;
    for (int k = 0; k < W / 4; k++) begin
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      // Group carry: generate/propagate of the whole nibble skips the inner chain.
      c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | ((&p[4*k +: 4]) & c[4*k]);
    end
  end

  always_ff @(posedge clk) begin
    s  <= p ^ c[W-1:0];
    co <= c[W];
  end

endmodule

// File: rtl/cla_mp_add_ctrl.sv
// Multi-precision add/subtract sequencer: streams WORDS operand words, LSW first,
// through one registered W-bit CLA and chains its registered carry between words.
module cla_mp_add_ctrl
  import cla_mp_add_ctrl_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int WORDS = WORDS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 sub,
  input  logic                 ci,
  input  logic [W*WORDS-1:0]   op_a,
  input  logic [W*WORDS-1:0]   op_b,
  output logic                 busy,
  output logic                 done,
  output logic [W*WORDS-1:0]   result,
  output logic                 co
);

  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
  logic               wr_vld_q, wr_vld_d;
  logic               cin0_q, cin0_d;
  logic [W*WORDS-1:0] a_q, a_d, b_q, b_d;
  logic [W*WORDS-1:0] result_q, result_d;
  logic               co_q, co_d;
  logic               accept;

  logic [W-1:0]       add_a, add_b, add_s;
  logic               add_ci, add_co;

  assign add_a  = a_q[idx_q*W +: W];
  assign add_b  = b_q[idx_q*W +: W];
  // Word 0 takes the latched initial carry; later words chain the adder's own carry.
  assign add_ci = (idx_q == '0) ? cin0_q : add_co;

  cla_word_reg #(.W(W)) u_word (
    .clk (clk),
    .a   (add_a),
    .b   (add_b),
    .ci  (add_ci),
    .co  (add_co),
    .s   (add_s)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    cin0_d   = cin0_q;
    result_d = result_q;
    co_d     = co_q;
    accept   = start && (state_q == ST_IDLE || state_q == ST_DONE);
    // Write-back trails issue by one cycle to cover the adder latency.
    wr_vld_d = (state_q == ST_RUN);
    wr_idx_d = idx_q;

    if (accept) begin
      a_d    = op_a;
      b_d    = sub ? ~op_b : op_b;
      cin0_d = sub ? 1'b1 : ci;
    end

    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = start ? ST_RUN : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (wr_vld_q) begin
      result_d[wr_idx_q*W +: W] = add_s;
      if (wr_idx_q == IDX_LAST) co_d = add_co;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      wr_idx_q <= '0;
      wr_vld_q <= 1'b0;
      cin0_q   <= 1'b0;
      result_q <= '0;
      co_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wr_idx_q <= wr_idx_d;
      wr_vld_q <= wr_vld_d;
      cin0_q   <= cin0_d;
      result_q <= result_d;
      co_q     <= co_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign busy   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign co     = co_q;

endmodule

// File: tb/tb_cla_mp_add_ctrl.sv
// Directed bench for cla_mp_add_ctrl with W=32, WORDS=4.
module tb_cla_mp_add_ctrl;

  logic         clk;
  logic         reset;
  logic         start;
  logic         sub;
  logic         ci;
  logic [127:0] op_a;
  logic [127:0] op_b;
  logic         busy;
  logic         done;
  logic [127:0] result;
  logic         co;

  int total;
  int bad;

  cla_mp_add_ctrl #(.W(32), .WORDS(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .sub    (sub),
    .ci     (ci),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .co     (co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One operation; pulse_cyc >= 0 raises start for that RUN cycle only.
  task automatic do_op(input string tag, input logic [127:0] a, input logic [127:0] b,
                       input logic s, input logic c, input logic [127:0] exp_r,
                       input logic exp_co, input int pulse_cyc);
    int cyc;
    int bcnt;
    @(negedge clk);
    op_a = a; op_b = b; sub = s; ci = c; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    op_a = ~a; op_b = ~b; ci = ~c; sub = ~s;
    cyc = 0;
    bcnt = 0;
    while (!done && cyc < 20) begin
      if (busy) bcnt++;
      start = (cyc == pulse_cyc);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 128'(cyc), 128'(5));
    chk({tag, "_busy_cycles"}, 128'(bcnt), 128'(4 + 1));
    chk({tag, "_result"}, result, exp_r);
    chk({tag, "_co"}, 128'(co), 128'(exp_co));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 128'(done), 128'(0));
    chk({tag, "_idle_after"}, 128'(busy), 128'(0));
    chk({tag, "_result_hold"}, result, exp_r);
  endtask

  initial begin
    int cyc;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    ci    = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_result", result, 128'(0));
    chk("rst_co", 128'(co), 128'(0));
    reset = 1'b0;

    do_op("xword", 128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h1, 1'b0, 1'b0,
          128'h00000001_00000000_00000000_00000000, 1'b0, -1);
    do_op("ripple", {128{1'b1}}, 128'h0, 1'b0, 1'b1, 128'h0, 1'b1, -1);
    do_op("single", 128'h135FA562, 128'h35614642, 1'b0, 1'b0, 128'h48C0EBA4, 1'b0, -1);
    do_op("sub5m3", 128'h5, 128'h3, 1'b1, 1'b0, 128'h2, 1'b1, -1);
    do_op("sub5m3_ci", 128'h5, 128'h3, 1'b1, 1'b1, 128'h2, 1'b1, -1);
    do_op("sub0m1", 128'h0, 128'h1, 1'b1, 1'b0, {128{1'b1}}, 1'b0, -1);
    do_op("sub0m1_ci", 128'h0, 128'h1, 1'b1, 1'b1, {128{1'b1}}, 1'b0, -1);
    do_op("run_pulse", 128'h7, 128'h8, 1'b0, 1'b0, 128'hF, 1'b0, 2);

    // Back-to-back: start held high straight through RUN and DONE.
    @(negedge clk);
    op_a = 128'h1; op_b = 128'h2; sub = 1'b0; ci = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b_first_latency", 128'(cyc), 128'(5));
    chk("b2b_first_result", result, 128'h3);
    op_a = 128'hA; op_b = 128'h14;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_reaccept_busy", 128'(busy), 128'(1));
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b_done_spacing", 128'(cyc), 128'(6));
    chk("b2b_second_result", result, 128'h1E);

    // Reset in the third RUN cycle discards the operation.
    @(negedge clk);
    op_a = 128'h3; op_b = 128'h4; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_done", 128'(done), 128'(0));
    chk("midrst_result", result, 128'h0);
    chk("midrst_co", 128'(co), 128'(0));
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_stays_idle", 128'(busy), 128'(0));
    do_op("after_rst", 128'h1, 128'h1, 1'b0, 1'b0, 128'h2, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
